// File: rtl/alu_issue_stage.sv
// Registered issue stage ahead of the MIPS ALU: decode, operand-B select/extend, 2-entry skid buffer.
// Optional perf counters (issued_cnt, stall_cnt) are built when ALU_ISSUE_PERF_EN is defined.
module alu_issue_stage #(
    parameter int WORD_SIZE = 32
`ifdef ALU_ISSUE_PERF_EN
    ,
    parameter int CNT_W     = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic [WORD_SIZE-1:0] rs_data,
    input  logic [WORD_SIZE-1:0] rt_data,
    input  logic [15:0]          imm16,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           alu_control,
    output logic [WORD_SIZE-1:0] alu_a,
    output logic [WORD_SIZE-1:0] alu_b,
    output logic                 illegal_op
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [CNT_W-1:0]     issued_cnt,
    output logic [CNT_W-1:0]     stall_cnt
`endif
);

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_NOR = 4'b1100;

    typedef struct packed {
        logic [3:0]           ctrl;
        logic [WORD_SIZE-1:0] a;
        logic [WORD_SIZE-1:0] b;
        logic                 illegal;
    } payload_t;

    payload_t              w_dec;
    payload_t              r_out;
    payload_t              r_skid;
    logic                  r_out_valid;
    logic                  r_skid_valid;
    logic                  w_accept;
    logic                  w_out_free;
    logic [WORD_SIZE-1:0]  w_sext;
    logic [WORD_SIZE-1:0]  w_zext;

    assign w_sext = {{(WORD_SIZE-16){imm16[15]}}, imm16};
    assign w_zext = {{(WORD_SIZE-16){1'b0}}, imm16};

    always_comb begin
        w_dec.ctrl    = CTRL_AND;
        w_dec.a       = rs_data;
        w_dec.b       = rt_data;
        w_dec.illegal = 1'b0;
        case (opcode)
            6'b000000: begin
                case (funct)
                    6'b100100: w_dec.ctrl = CTRL_AND;
                    6'b100101: w_dec.ctrl = CTRL_OR;
                    6'b100000: w_dec.ctrl = CTRL_ADD;
                    6'b100010: w_dec.ctrl = CTRL_SUB;
                    6'b101010: w_dec.ctrl = CTRL_SLT;
                    6'b100111: w_dec.ctrl = CTRL_NOR;
                    default:   w_dec.illegal = 1'b1;
                endcase
            end
            6'b100011, 6'b101011, 6'b001000: begin
                w_dec.ctrl = CTRL_ADD;
                w_dec.b    = w_sext;
            end
            6'b001010: begin
                w_dec.ctrl = CTRL_SLT;
                w_dec.b    = w_sext;
            end
            6'b001100: begin
                w_dec.ctrl = CTRL_AND;
                w_dec.b    = w_zext;
            end
            6'b001101: begin
                w_dec.ctrl = CTRL_OR;
                w_dec.b    = w_zext;
            end
            6'b000100: w_dec.ctrl = CTRL_SUB;
            default:   w_dec.illegal = 1'b1;
        endcase
    end

    // Ready depends only on skid occupancy (and flush), never on out_ready.
    assign in_ready   = !r_skid_valid && !flush;
    assign w_accept   = in_valid && in_ready;
    assign w_out_free = !r_out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_out        <= '0;
            r_skid       <= '0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_out_free) begin
            // Skid drains first; in_ready was low so nothing new arrives that edge.
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_valid <= w_accept;
                if (w_accept) r_out <= w_dec;
            end
        end else if (w_accept) begin
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
        end
    end

    assign out_valid   = r_out_valid;
    assign alu_control = r_out.ctrl;
    assign alu_a       = r_out.a;
    assign alu_b       = r_out.b;
    assign illegal_op  = r_out.illegal;

`ifdef ALU_ISSUE_PERF_EN
    logic [CNT_W-1:0] r_issued_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issued_cnt <= '0;
            r_stall_cnt  <= '0;
        end else if (flush) begin
            r_issued_cnt <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (r_out_valid && out_ready && r_issued_cnt != '1)
                r_issued_cnt <= r_issued_cnt + CNT_W'(1);
            if (r_out_valid && !out_ready && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign issued_cnt = r_issued_cnt;
    assign stall_cnt  = r_stall_cnt;
`endif

endmodule
